// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
//   Bit-serial receiver for XOR-parity-protected frames. Each frame is
//   DATA_WIDTH data bits (LSB first) followed by one parity bit. The parity is
//   recomputed with a running XOR. Each completed word is presented on a
//   1-entry valid/ready output buffer together with its parity-error flag.
//
// Parameters
//   DATA_WIDTH  data bits per frame (>= 2)
//   ODD_PARITY  0: XOR of data and parity must be 0; 1: it must be 1
//   ERR_CNT_W   width of the saturating parity-error counter
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   in_valid        in_bit is valid this cycle
//   in_bit          serial data/parity bit
//   in_ready        receiver accepts a bit this cycle (combinational from out_ready)
//   in_abort        discard the partially received frame (synchronous)
//   out_data        received word
//   out_parity_err  parity mismatch for the word in out_data
//   out_valid       out_data/out_parity_err valid
//   out_ready       consumer accepts the word when out_valid && out_ready
//   err_count       number of frames received with a parity error (saturating)
// -----------------------------------------------------------------------------
module parity_frame_rx #(
    parameter int DATA_WIDTH = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  in_ready,
    input  logic                  in_abort,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_parity_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par;

    logic                    take;
    logic                    data_take;
    logic                    load;
    logic                    frame_err;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Only the parity bit can stall: it would load the buffer, which is
    // occupied unless the consumer drains it on this same edge.
    always_comb begin
        in_ready  = !(state == ST_PARITY && out_valid && !out_ready);
        take      = in_valid && in_ready && !in_abort;
        data_take = take && (state == ST_DATA);
        load      = take && (state == ST_PARITY);
        frame_err = par ^ in_bit ^ ODD_PARITY;
    end

    always_comb begin
        state_next = state;
        if (in_abort) begin
            state_next = ST_DATA;
        end else if (data_take && bit_cnt == LAST_BIT) begin
            state_next = ST_PARITY;
        end else if (load) begin
            state_next = ST_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DATA;
        end else begin
            state <= state_next;
        end
    end

    // Frame assembly: shift register, bit counter, running parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par       <= 1'b0;
        end else if (in_abort) begin
            bit_cnt <= '0;
            par     <= 1'b0;
        end else if (data_take) begin
            shift_reg[bit_cnt] <= in_bit;
            par                <= par ^ in_bit;
            bit_cnt            <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
        end else if (load) begin
            par <= 1'b0;
        end
    end

    // Output buffer and error counter. A load on the same edge as a consumer
    // handshake replaces the word and keeps out_valid asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data       <= '0;
            out_parity_err <= 1'b0;
            out_valid      <= 1'b0;
            err_count      <= '0;
        end else begin
            if (load) begin
                out_data       <= shift_reg;
                out_parity_err <= frame_err;
                out_valid      <= 1'b1;
                if (frame_err) begin
                    err_count <= sat_inc(err_count);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
